// File: rtl/stage5_control_fsm.sv
// Stage-5 stack-machine control unit: a Moore FSM that sequences FETCH/DECODE/EX
// and drives the datapath strobes from the current state and the latched opcode.
module stage5_control_fsm (
   input  logic        CLK,
   input  logic        RegReset,
   input  logic        Run,
   input  logic [15:0] IROut,
   output logic        PCWrite,
   output logic        PCSource,
   output logic        PCAdd,
   output logic        MSPWrite,
   output logic        MSPop,
   output logic        RSPWrite,
   output logic        RSPop,
   output logic        ValAWrite,
   output logic        ValBWrite,
   output logic        IRWrite,
   output logic        MemRead1,
   output logic        MemRead2,
   output logic        MemWrite1,
   output logic        MemWrite2,
   output logic [1:0]  MemDst1,
   output logic [1:0]  MemDst2,
   output logic [1:0]  MemData,
   output logic        PCRegReset,
   output logic        MSPRegReset,
   output logic        RSPRegReset,
   output logic        Halted,
   output logic [2:0]  State
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EX1    = 3'd3,
      EX2    = 3'd4,
      EX3    = 3'd5,
      HALT   = 3'd6
   } stateT;

   typedef struct packed {
      logic       pcWrite;
      logic       pcSource;
      logic       pcAdd;
      logic       mspWrite;
      logic       mspPop;
      logic       rspWrite;
      logic       rspPop;
      logic       valAWrite;
      logic       valBWrite;
      logic       irWrite;
      logic       memRead1;
      logic       memRead2;
      logic       memWrite1;
      logic       memWrite2;
      logic [1:0] memDst1;
      logic [1:0] memDst2;
      logic [1:0] memData;
      logic       halted;
   } ctrlT;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_PUSHI = 4'h1;
   localparam logic [3:0] OP_ALU   = 4'h2;
   localparam logic [3:0] OP_JMP   = 4'h3;
   localparam logic [3:0] OP_CALL  = 4'h4;
   localparam logic [3:0] OP_RET   = 4'h5;

   localparam logic [1:0] DST1_MSP  = 2'd1;
   localparam logic [1:0] DST2_MSP  = 2'd0;
   localparam logic [1:0] DST2_RSP  = 2'd1;
   localparam logic [1:0] DATA_PC   = 2'd0;
   localparam logic [1:0] DATA_RES  = 2'd1;
   localparam logic [1:0] DATA_ZEIM = 2'd2;

   localparam ctrlT CTRL_NONE = ctrlT'(21'd0);

   // Strobe pattern for a given state/opcode pair; unlisted strobes stay 0.
   function automatic ctrlT decodeCtrl(input stateT st, input logic [3:0] op);
      ctrlT c;
      c = CTRL_NONE;
      case (st)
         FETCH: begin
            c.memRead1 = 1'b1;
            c.irWrite  = 1'b1;
            c.pcWrite  = 1'b1;
         end
         EX1: begin
            case (op)
               OP_PUSHI: c.mspWrite = 1'b1;
               OP_ALU: begin
                  c.memRead1  = 1'b1;
                  c.memDst1   = DST1_MSP;
                  c.valAWrite = 1'b1;
                  c.mspWrite  = 1'b1;
                  c.mspPop    = 1'b1;
               end
               OP_JMP: begin
                  c.pcWrite = 1'b1;
                  c.pcAdd   = 1'b1;
               end
               OP_CALL: begin
                  c.rspWrite  = 1'b1;
                  c.memRead1  = 1'b1;
                  c.memDst1   = DST1_MSP;
                  c.valAWrite = 1'b1;
               end
               OP_RET: begin
                  c.memRead2  = 1'b1;
                  c.memDst2   = DST2_RSP;
                  c.valBWrite = 1'b1;
                  c.rspWrite  = 1'b1;
                  c.rspPop    = 1'b1;
               end
               default: c = CTRL_NONE;
            endcase
         end
         EX2: begin
            case (op)
               OP_PUSHI: begin
                  c.memWrite1 = 1'b1;
                  c.memDst1   = DST1_MSP;
                  c.memData   = DATA_ZEIM;
               end
               OP_ALU: begin
                  c.memRead2  = 1'b1;
                  c.memDst2   = DST2_MSP;
                  c.valBWrite = 1'b1;
               end
               OP_CALL: begin
                  c.memWrite2 = 1'b1;
                  c.memDst2   = DST2_RSP;
                  c.memData   = DATA_PC;
               end
               OP_RET: begin
                  c.pcWrite  = 1'b1;
                  c.pcSource = 1'b1;
               end
               default: c = CTRL_NONE;
            endcase
         end
         EX3: begin
            case (op)
               OP_ALU: begin
                  c.memWrite1 = 1'b1;
                  c.memDst1   = DST1_MSP;
                  c.memData   = DATA_RES;
               end
               OP_CALL: begin
                  c.pcWrite  = 1'b1;
                  c.pcSource = 1'b1;
               end
               default: c = CTRL_NONE;
            endcase
         end
         HALT:    c.halted = 1'b1;
         default: c = CTRL_NONE;
      endcase
      return c;
   endfunction

   stateT      state_r;
   stateT      nextState_s;
   logic [3:0] opcode_r;
   logic [3:0] nextOpcode_s;
   ctrlT       ctrl_r;
   ctrlT       ctrlOut_s;
   logic       unusedIrBits_s;

   assign unusedIrBits_s = ^IROut[11:0];

   // Opcode is captured only while decoding, so EX states see a stable value.
   always_comb begin
      nextOpcode_s = opcode_r;
      if (state_r == DECODE) begin
         nextOpcode_s = IROut[15:12];
      end else begin
         nextOpcode_s = opcode_r;
      end
   end

   // Next-state sequencing; unreachable combinations fall into HALT.
   always_comb begin
      nextState_s = state_r;
      case (state_r)
         IDLE: begin
            if (Run) begin
               nextState_s = FETCH;
            end else begin
               nextState_s = IDLE;
            end
         end
         FETCH: nextState_s = DECODE;
         DECODE: begin
            case (IROut[15:12])
               OP_NOP:                                  nextState_s = FETCH;
               OP_PUSHI, OP_ALU, OP_JMP, OP_CALL, OP_RET: nextState_s = EX1;
               default:                                 nextState_s = HALT;
            endcase
         end
         EX1: begin
            case (opcode_r)
               OP_JMP:                            nextState_s = FETCH;
               OP_PUSHI, OP_ALU, OP_CALL, OP_RET: nextState_s = EX2;
               default:                           nextState_s = HALT;
            endcase
         end
         EX2: begin
            case (opcode_r)
               OP_PUSHI, OP_RET: nextState_s = FETCH;
               OP_ALU, OP_CALL:  nextState_s = EX3;
               default:          nextState_s = HALT;
            endcase
         end
         EX3: begin
            case (opcode_r)
               OP_ALU, OP_CALL: nextState_s = FETCH;
               default:         nextState_s = HALT;
            endcase
         end
         HALT:    nextState_s = HALT;
         default: nextState_s = HALT;
      endcase
   end

   // State, opcode and strobe registers; strobes are decoded one cycle early
   // from the next state so they line up with the state they belong to.
   always_ff @(posedge CLK) begin
      if (RegReset) begin
         state_r  <= IDLE;
         opcode_r <= 4'h0;
         ctrl_r   <= CTRL_NONE;
      end else begin
         state_r  <= nextState_s;
         opcode_r <= nextOpcode_s;
         ctrl_r   <= decodeCtrl(nextState_s, nextOpcode_s);
      end
   end

   // Reset blanks every strobe immediately, not just after the next edge.
   always_comb begin
      ctrlOut_s = CTRL_NONE;
      if (RegReset) begin
         ctrlOut_s = CTRL_NONE;
      end else begin
         ctrlOut_s = ctrl_r;
      end
   end

   assign PCWrite     = ctrlOut_s.pcWrite;
   assign PCSource    = ctrlOut_s.pcSource;
   assign PCAdd       = ctrlOut_s.pcAdd;
   assign MSPWrite    = ctrlOut_s.mspWrite;
   assign MSPop       = ctrlOut_s.mspPop;
   assign RSPWrite    = ctrlOut_s.rspWrite;
   assign RSPop       = ctrlOut_s.rspPop;
   assign ValAWrite   = ctrlOut_s.valAWrite;
   assign ValBWrite   = ctrlOut_s.valBWrite;
   assign IRWrite     = ctrlOut_s.irWrite;
   assign MemRead1    = ctrlOut_s.memRead1;
   assign MemRead2    = ctrlOut_s.memRead2;
   assign MemWrite1   = ctrlOut_s.memWrite1;
   assign MemWrite2   = ctrlOut_s.memWrite2;
   assign MemDst1     = ctrlOut_s.memDst1;
   assign MemDst2     = ctrlOut_s.memDst2;
   assign MemData     = ctrlOut_s.memData;
   assign Halted      = ctrlOut_s.halted;
   assign State       = RegReset ? 3'd0 : state_r;
   assign PCRegReset  = RegReset | (state_r == IDLE);
   assign MSPRegReset = RegReset | (state_r == IDLE);
   assign RSPRegReset = RegReset | (state_r == IDLE);

   stage5_control_fsm_checker uChecker (
      .CLK       (CLK),
      .RegReset  (RegReset),
      .PCWrite   (PCWrite),
      .IRWrite   (IRWrite),
      .MemWrite1 (MemWrite1),
      .MemWrite2 (MemWrite2),
      .State     (State)
   );

endmodule

// Protocol properties of the control outputs: single memory write per cycle,
// and PC/IR written together only during FETCH.
module stage5_control_fsm_checker (
   input logic       CLK,
   input logic       RegReset,
   input logic       PCWrite,
   input logic       IRWrite,
   input logic       MemWrite1,
   input logic       MemWrite2,
   input logic [2:0] State
);

   assert property (@(posedge CLK) disable iff (RegReset) !(MemWrite1 && MemWrite2));
   assert property (@(posedge CLK) disable iff (RegReset)
                    (PCWrite && IRWrite) |-> (State == 3'd1));

endmodule

// File: tb/tb_stage5_control_fsm.sv
// Directed bench for stage5_control_fsm: walks every opcode, HALT and mid-instruction reset.
module tb_stage5_control_fsm;

   logic        CLK;
   logic        RegReset;
   logic        Run;
   logic [15:0] IROut;
   logic        PCWrite, PCSource, PCAdd, MSPWrite, MSPop, RSPWrite, RSPop;
   logic        ValAWrite, ValBWrite, IRWrite, MemRead1, MemRead2, MemWrite1, MemWrite2;
   logic [1:0]  MemDst1, MemDst2, MemData;
   logic        PCRegReset, MSPRegReset, RSPRegReset, Halted;
   logic [2:0]  State;

   int nChecks = 0;
   int nFails  = 0;

   stage5_control_fsm dut (
      .CLK(CLK), .RegReset(RegReset), .Run(Run), .IROut(IROut),
      .PCWrite(PCWrite), .PCSource(PCSource), .PCAdd(PCAdd),
      .MSPWrite(MSPWrite), .MSPop(MSPop), .RSPWrite(RSPWrite), .RSPop(RSPop),
      .ValAWrite(ValAWrite), .ValBWrite(ValBWrite), .IRWrite(IRWrite),
      .MemRead1(MemRead1), .MemRead2(MemRead2), .MemWrite1(MemWrite1), .MemWrite2(MemWrite2),
      .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData),
      .PCRegReset(PCRegReset), .MSPRegReset(MSPRegReset), .RSPRegReset(RSPRegReset),
      .Halted(Halted), .State(State)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Bit positions of the packed strobe vector used for comparisons.
   localparam logic [19:0] S_PCW    = 20'd1 << 19;
   localparam logic [19:0] S_PCSRC  = 20'd1 << 18;
   localparam logic [19:0] S_PCADD  = 20'd1 << 17;
   localparam logic [19:0] S_MSPW   = 20'd1 << 16;
   localparam logic [19:0] S_MSPPOP = 20'd1 << 15;
   localparam logic [19:0] S_RSPW   = 20'd1 << 14;
   localparam logic [19:0] S_RSPPOP = 20'd1 << 13;
   localparam logic [19:0] S_VAW    = 20'd1 << 12;
   localparam logic [19:0] S_VBW    = 20'd1 << 11;
   localparam logic [19:0] S_IRW    = 20'd1 << 10;
   localparam logic [19:0] S_MR1    = 20'd1 << 9;
   localparam logic [19:0] S_MR2    = 20'd1 << 8;
   localparam logic [19:0] S_MW1    = 20'd1 << 7;
   localparam logic [19:0] S_MW2    = 20'd1 << 6;
   localparam logic [19:0] D1_MSP   = 20'd1 << 4;
   localparam logic [19:0] D2_RSP   = 20'd1 << 2;
   localparam logic [19:0] DATA_RES = 20'd1;
   localparam logic [19:0] DATA_ZE  = 20'd2;
   localparam logic [19:0] NONE     = 20'd0;

   localparam logic [19:0] E_FETCH   = S_MR1 | S_IRW | S_PCW;
   localparam logic [19:0] E_PUSHI1  = S_MSPW;
   localparam logic [19:0] E_PUSHI2  = S_MW1 | D1_MSP | DATA_ZE;
   localparam logic [19:0] E_ALU1    = S_MR1 | D1_MSP | S_VAW | S_MSPW | S_MSPPOP;
   localparam logic [19:0] E_ALU2    = S_MR2 | S_VBW;
   localparam logic [19:0] E_ALU3    = S_MW1 | D1_MSP | DATA_RES;
   localparam logic [19:0] E_JMP1    = S_PCW | S_PCADD;
   localparam logic [19:0] E_CALL1   = S_RSPW | S_MR1 | D1_MSP | S_VAW;
   localparam logic [19:0] E_CALL2   = S_MW2 | D2_RSP;
   localparam logic [19:0] E_CALL3   = S_PCW | S_PCSRC;
   localparam logic [19:0] E_RET1    = S_MR2 | D2_RSP | S_VBW | S_RSPW | S_RSPPOP;
   localparam logic [19:0] E_RET2    = S_PCW | S_PCSRC;

   logic [19:0] obsStrobes;
   assign obsStrobes = {PCWrite, PCSource, PCAdd, MSPWrite, MSPop, RSPWrite, RSPop,
                        ValAWrite, ValBWrite, IRWrite, MemRead1, MemRead2,
                        MemWrite1, MemWrite2, MemDst1, MemDst2, MemData};

   task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      if (observed !== expected) begin
         nFails++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Entered in FETCH; leaves the FSM in the following FETCH.
   task automatic runInstr(input string name, input logic [15:0] ir, input int nEx,
                           input logic [19:0] e1, input logic [19:0] e2, input logic [19:0] e3);
      logic [19:0] exps [3];
      exps[0] = e1;
      exps[1] = e2;
      exps[2] = e3;
      IROut = ir;
      checkEq({name, " fetch state"}, 32'(State), 32'd1);
      checkEq({name, " fetch strobes"}, 32'(obsStrobes), 32'(E_FETCH));
      step();
      checkEq({name, " decode state"}, 32'(State), 32'd2);
      checkEq({name, " decode strobes"}, 32'(obsStrobes), 32'(NONE));
      for (int k = 0; k < nEx; k++) begin
         step();
         checkEq($sformatf("%s ex%0d state", name, k + 1), 32'(State), 32'(3 + k));
         checkEq($sformatf("%s ex%0d strobes", name, k + 1), 32'(obsStrobes), 32'(exps[k]));
         checkEq($sformatf("%s ex%0d memwr excl", name, k + 1), 32'(MemWrite1 & MemWrite2), 32'd0);
         checkEq($sformatf("%s ex%0d halted", name, k + 1), 32'(Halted), 32'd0);
      end
      step();
   endtask

   initial begin
      RegReset = 1'b1;
      Run      = 1'b0;
      IROut    = 16'h0000;
      step();
      step();
      checkEq("reset state", 32'(State), 32'd0);
      checkEq("reset strobes", 32'(obsStrobes), 32'(NONE));
      checkEq("reset halted", 32'(Halted), 32'd0);
      checkEq("reset regresets", 32'({PCRegReset, MSPRegReset, RSPRegReset}), 32'd7);

      RegReset = 1'b0;
      step();
      checkEq("idle no run", 32'(State), 32'd0);
      checkEq("idle regresets", 32'({PCRegReset, MSPRegReset, RSPRegReset}), 32'd7);
      checkEq("idle strobes", 32'(obsStrobes), 32'(NONE));

      Run = 1'b1;
      step();
      Run = 1'b0;
      checkEq("fetch regresets", 32'({PCRegReset, MSPRegReset, RSPRegReset}), 32'd0);

      runInstr("nop1",  16'h0000, 0, NONE, NONE, NONE);
      runInstr("nop2",  16'h0000, 0, NONE, NONE, NONE);
      runInstr("pushi", 16'h1005, 2, E_PUSHI1, E_PUSHI2, NONE);
      runInstr("alu",   16'h2000, 3, E_ALU1, E_ALU2, E_ALU3);
      runInstr("jmp",   16'h3ABC, 1, E_JMP1, NONE, NONE);
      runInstr("call",  16'h4000, 3, E_CALL1, E_CALL2, E_CALL3);
      runInstr("ret",   16'h5000, 2, E_RET1, E_RET2, NONE);

      IROut = 16'h7000;
      step();
      step();
      checkEq("halt state", 32'(State), 32'd6);
      checkEq("halt halted", 32'(Halted), 32'd1);
      checkEq("halt strobes", 32'(obsStrobes), 32'(NONE));
      for (int i = 0; i < 10; i++) begin
         Run = ~Run;
         step();
         checkEq($sformatf("halt hold %0d", i), 32'(State), 32'd6);
      end

      RegReset = 1'b1;
      Run      = 1'b0;
      step();
      checkEq("halt reset state", 32'(State), 32'd0);
      checkEq("halt reset halted", 32'(Halted), 32'd0);
      checkEq("halt reset regresets", 32'({PCRegReset, MSPRegReset, RSPRegReset}), 32'd7);
      RegReset = 1'b0;
      step();
      checkEq("post halt idle", 32'(State), 32'd0);

      Run   = 1'b1;
      IROut = 16'h2000;
      step();
      Run = 1'b0;
      checkEq("alu2 fetch", 32'(State), 32'd1);
      step();
      step();
      checkEq("alu2 ex1", 32'(State), 32'd3);
      step();
      checkEq("alu2 ex2", 32'(State), 32'd4);
      checkEq("alu2 ex2 strobes", 32'(obsStrobes), 32'(E_ALU2));
      RegReset = 1'b1;
      step();
      checkEq("mid reset state", 32'(State), 32'd0);
      checkEq("mid reset strobes", 32'(obsStrobes), 32'(NONE));
      checkEq("mid reset regresets", 32'({PCRegReset, MSPRegReset, RSPRegReset}), 32'd7);
      RegReset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checkEq($sformatf("mid reset idle %0d", i), 32'(State), 32'd0);
         checkEq($sformatf("mid reset no memwr1 %0d", i), 32'(MemWrite1), 32'd0);
      end

      Run   = 1'b1;
      IROut = 16'h0000;
      step();
      Run = 1'b0;
      checkEq("restart fetch", 32'(State), 32'd1);
      step();
      checkEq("restart decode", 32'(State), 32'd2);
      step();
      checkEq("restart nop fetch", 32'(State), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
